id_stage: RTL and testbench

Instruction-decode stage of the RISC-V core. It sits between fetch and execute, drives the register file read ports, and registers operands, immediate and control fields into the ID/EX pipeline register. A per-register busy scoreboard stalls fetch on read-after-write hazards. It also accepts a flush from the branch unit.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/imm_gen.sv | 35 +++
 rtl/id_stage.sv | 177 +++++++++++++++++
 tb/tb_id_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode constants and immediate format enum
//
// Purpose: opcode values of the RV32I base set recognised by decode, and the
//          immediate-format selector shared between id_stage and imm_gen.
// Ports:   none (package).
package riscv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // IMM_R means "no immediate": R-type and illegal opcodes produce zero.
  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate generator
//
// Purpose: assembles the sign-extended immediate for the selected format.
// Ports:
//   instr    in  32    instruction word
//   imm_type in  enum  immediate format (IMM_R gives zero)
//   imm      out XLEN  immediate, sign-extended from instr[31]
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widening to XLEN keeps the sign of the 32-bit immediate.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RISC-V decode stage with busy scoreboard and ID/EX register
//
// Purpose: decodes the fetched instruction, reads the register file, stalls
//          fetch on read-after-write hazards and registers the decoded
//          instruction into the ID/EX pipeline register.
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   if_valid/if_ready           fetch handshake; if_ready is combinational
//   if_instr, if_pc             instruction word and its PC
//   rf_raddr1/2, rf_rdata1/2    register file read ports (rs1/rs2 fields)
//   wb_wen, wb_waddr            writeback strobe, clears the busy bit
//   flush                       kills ID/EX and the instruction at the input
//   ex_valid/ex_ready           execute handshake
//   ex_pc .. ex_illegal         registered decode results
module id_stage
  import riscv_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [RW-1:0]   rf_raddr1,
  output logic [RW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_wen,
  input  logic [RW-1:0]   wb_waddr,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [RW-1:0]   ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic            ex_we,
  output logic            ex_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RW-1:0]   rs1, rs2, rd;
  logic            legal, uses_rs1, uses_rs2, writes_rd, we;
  imm_type_e       imm_type;
  logic [XLEN-1:0] imm;
  logic [NREG-1:0] busy, busy_next;
  logic            haz1, haz2, hazard, slot_free, accept, ex_hs;

  assign opcode = if_instr[6:0];
  assign rd     = RW'(if_instr[11:7]);
  assign funct3 = if_instr[14:12];
  assign rs1    = RW'(if_instr[19:15]);
  assign rs2    = RW'(if_instr[24:20]);
  assign funct7 = if_instr[31:25];

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  always_comb begin
    legal     = 1'b1;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b1;
    imm_type  = IMM_R;
    unique case (opcode)
      OP: uses_rs2 = 1'b1;
      OP_IMM, LOAD, JALR, SYSTEM: imm_type = IMM_I;
      STORE: begin
        imm_type  = IMM_S;
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
      end
      BRANCH: begin
        imm_type  = IMM_B;
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
      end
      LUI, AUIPC: begin
        imm_type = IMM_U;
        uses_rs1 = 1'b0;
      end
      JAL: begin
        imm_type = IMM_J;
        uses_rs1 = 1'b0;
      end
      default: begin
        // Illegal instructions flow down the pipe but never read or write
        // registers, so they are exempt from hazard checking.
        legal     = 1'b0;
        uses_rs1  = 1'b0;
        writes_rd = 1'b0;
      end
    endcase
  end

  assign we = writes_rd && (rd != '0);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (if_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  // A busy source is released in the cycle its writeback lands, since the
  // register file forwards that write onto rf_rdata. The instruction in
  // ID/EX has not yet marked the scoreboard, so it is checked directly.
  always_comb begin
    haz1 = uses_rs1 && (rs1 != '0) &&
           ((busy[rs1] && !(wb_wen && wb_waddr == rs1)) ||
            (ex_valid && ex_we && ex_rd == rs1));
    haz2 = uses_rs2 && (rs2 != '0) &&
           ((busy[rs2] && !(wb_wen && wb_waddr == rs2)) ||
            (ex_valid && ex_we && ex_rd == rs2));
  end

  assign hazard    = haz1 || haz2;
  assign slot_free = !ex_valid || ex_ready;
  assign if_ready  = slot_free && !hazard && !flush;
  assign accept    = if_valid && if_ready;
  assign ex_hs     = ex_valid && ex_ready;

  // Set is applied after clear so a same-cycle handoff to the register
  // being written back leaves it busy. Flush leaves the scoreboard alone:
  // writebacks for older instructions are still on their way.
  always_comb begin
    busy_next = busy;
    if (wb_wen) busy_next[wb_waddr] = 1'b0;
    if (ex_hs && ex_we) busy_next[ex_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_opcode  <= '0;
      ex_funct3  <= '0;
      ex_funct7  <= '0;
      ex_we      <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_pc      <= if_pc;
      ex_rs1_val <= rf_rdata1;
      ex_rs2_val <= rf_rdata2;
      ex_imm     <= imm;
      ex_rd      <= rd;
      ex_opcode  <= opcode;
      ex_funct3  <= funct3;
      ex_funct7  <= funct7;
      ex_we      <= we;
      ex_illegal <= !legal;
    end else if (ex_ready || flush) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage
module tb_id_stage;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            if_valid, if_ready, wb_wen, flush, ex_valid, ex_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc, rf_rdata1, rf_rdata2, wb_wdata;
  logic [RW-1:0]   rf_raddr1, rf_raddr2, wb_waddr, ex_rd;
  logic [XLEN-1:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [6:0]      ex_opcode, ex_funct7;
  logic [2:0]      ex_funct3;
  logic            ex_we, ex_illegal;

  always #5 clk = ~clk;

  id_stage #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_we(ex_we), .ex_illegal(ex_illegal)
  );

  typedef enum logic [3:0] {
    K_ADDI, K_ADD, K_LW, K_SW, K_BEQ, K_LUI, K_AUIPC, K_JAL, K_JALR, K_SYS, K_ILL
  } kind_e;
  localparam int NKIND = 11;

  typedef struct {
    bit          valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rd;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    bit          we, ill;
  } ex_t;

  // Reference model: architectural register file, busy set, ID/EX contents.
  logic [31:0] regs [NREG];
  bit          mbusy [NREG];
  ex_t         mex;
  kind_e       cur_kind;
  logic [4:0]  cur_rs1, cur_rs2;
  logic [31:0] cur_imm;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic bit k_uses1(kind_e k);
    return !(k inside {K_LUI, K_AUIPC, K_JAL, K_ILL});
  endfunction
  function automatic bit k_uses2(kind_e k);
    return k inside {K_ADD, K_SW, K_BEQ};
  endfunction
  function automatic bit k_writes(kind_e k);
    return !(k inside {K_SW, K_BEQ, K_ILL});
  endfunction

  function automatic logic [31:0] rdv(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_wen && wb_waddr == a) return wb_wdata;
    return regs[a];
  endfunction

  function automatic bit src_busy(logic [4:0] s);
    if (s == 0) return 1'b0;
    return (mbusy[s] && !(wb_wen && wb_waddr == s)) || (mex.valid && mex.we && mex.rd == s);
  endfunction

  function automatic bit exp_ready();
    bit haz;
    haz = (k_uses1(cur_kind) && src_busy(cur_rs1)) || (k_uses2(cur_kind) && src_busy(cur_rs2));
    return (!mex.valid || ex_ready) && !haz && !flush;
  endfunction

  // Random immediate that is representable in the format of kind k.
  function automatic logic [31:0] rand_imm(kind_e k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADDI, K_LW, K_JALR, K_SYS, K_SW: return {{20{r[11]}}, r[11:0]};
      K_BEQ:          return {{19{r[12]}}, r[12:1], 1'b0};
      K_LUI, K_AUIPC: return {r[31:12], 12'h0};
      K_JAL:          return {{11{r[20]}}, r[20:1], 1'b0};
      default:        return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    mex = '{valid: 1'b0, pc: 0, rs1v: 0, rs2v: 0, imm: 0, rd: 0, op: 0, f7: 0, f3: 0, we: 1'b0, ill: 1'b0};
    for (int i = 0; i < NREG; i++) mbusy[i] = 1'b0;
  endfunction

  // Encode an instruction from its fields at the next falling edge.
  task automatic drive(input bit v, input kind_e k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input bit exr,
                       input bit wen, input logic [4:0] wa, input bit fl);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] junk;
    @(negedge clk);
    f3 = 3'($urandom);
    f7 = 7'($urandom);
    junk = $urandom;
    case (k)
      K_ADDI:  if_instr = {imm[11:0], rs1, f3, rd, 7'h13};
      K_LW:    if_instr = {imm[11:0], rs1, f3, rd, 7'h03};
      K_JALR:  if_instr = {imm[11:0], rs1, f3, rd, 7'h67};
      K_SYS:   if_instr = {imm[11:0], rs1, f3, rd, 7'h73};
      K_ADD:   if_instr = {f7, rs2, rs1, f3, rd, 7'h33};
      K_SW:    if_instr = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
      K_BEQ:   if_instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
      K_LUI:   if_instr = {imm[31:12], rd, 7'h37};
      K_AUIPC: if_instr = {imm[31:12], rd, 7'h17};
      K_JAL:   if_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
      default: if_instr = {junk[24:0], 7'h7F};
    endcase
    cur_kind = k;
    cur_rs1  = rs1;
    cur_rs2  = rs2;
    cur_imm  = (k == K_ADD || k == K_ILL) ? 32'h0 : imm;
    if_valid = v;
    if_pc    = $urandom;
    ex_ready = exr;
    wb_wen   = wen;
    wb_waddr = wa;
    wb_wdata = $urandom;
    flush    = fl;
    rf_rdata1 = rdv(if_instr[19:15]);
    rf_rdata2 = rdv(if_instr[24:20]);
    #1;
  endtask

  // Advance one clock and update the model from the inputs of that cycle.
  task automatic tick();
    bit acc, hs;
    @(posedge clk);
    acc = if_valid && exp_ready();
    hs  = mex.valid && ex_ready;
    if (wb_wen) mbusy[wb_waddr] = 1'b0;
    if (hs && mex.we) mbusy[mex.rd] = 1'b1;
    mbusy[0] = 1'b0;
    if (wb_wen && wb_waddr != 0) regs[wb_waddr] = wb_wdata;
    if (acc) begin
      mex.valid = 1'b1;
      mex.pc = if_pc;  mex.rs1v = rf_rdata1;  mex.rs2v = rf_rdata2;  mex.imm = cur_imm;
      mex.rd = if_instr[11:7];  mex.op = if_instr[6:0];  mex.f3 = if_instr[14:12];
      mex.f7 = if_instr[31:25];
      mex.we = k_writes(cur_kind) && if_instr[11:7] != 0;
      mex.ill = (cur_kind == K_ILL);
    end else if (ex_ready || flush) begin
      mex.valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [151:0] got;
    rst = 1'b1;
    if_valid = 0; if_instr = 0; if_pc = 0; ex_ready = 0; wb_wen = 0; wb_waddr = 0;
    wb_wdata = 0; flush = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    cur_kind = K_ILL; cur_rs1 = 0; cur_rs2 = 0; cur_imm = 0;
    regs[0] = 0;
    for (int i = 1; i < NREG; i++) regs[i] = $urandom;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7, ex_we, ex_illegal};
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    n_cmp++; if (got !== 152'h0) begin n_bad++; $display("FAIL reset_ex_fields: got %h want 0", got); end
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL reset_if_ready: got %b want 1", if_ready); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    drive(1, K_ADDI, 5, 0, 0, 7, 1, 0, 0, 0);
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL addi_if_ready: got %b want 1", if_ready); end
    tick();
    n_cmp++;
    if ({ex_valid, ex_rd, ex_imm, ex_we, ex_rs1_val} !== {1'b1, 5'd5, 32'd7, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL addi_ex: got v=%b rd=%0d imm=%h we=%b rs1=%h want v=1 rd=5 imm=7 we=1 rs1=0",
               ex_valid, ex_rd, ex_imm, ex_we, ex_rs1_val);
    end
  endtask

  task automatic test_raw();
    logic [31:0] wd;
    for (int c = 0; c < 3; c++) begin
      drive(1, K_ADD, 6, 5, 1, 0, 1, 0, 0, 0);
      n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall c%0d: got %b want 0", c, if_ready); end
      tick();
    end
    drive(1, K_ADD, 6, 5, 1, 0, 1, 1, 5, 0);
    wd = wb_wdata;
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL raw_release: got %b want 1", if_ready); end
    tick();
    n_cmp++;
    if ({ex_valid, ex_rd, ex_rs1_val, ex_rs2_val} !== {1'b1, 5'd6, wd, regs[1]}) begin
      n_bad++;
      $display("FAIL raw_operands: got v=%b rd=%0d rs1=%h rs2=%h want v=1 rd=6 rs1=%h rs2=%h",
               ex_valid, ex_rd, ex_rs1_val, ex_rs2_val, wd, regs[1]);
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 3; c++) begin
      drive(1, K_ADDI, 7, 0, 0, 3, 0, 0, 0, 0);
      n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL stall_if_ready c%0d: got %b want 0", c, if_ready); end
      tick();
      n_cmp++;
      if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) begin
        n_bad++; $display("FAIL stall_hold c%0d: got v=%b rd=%0d want v=1 rd=6", c, ex_valid, ex_rd);
      end
    end
    drive(1, K_ADDI, 7, 0, 0, 3, 1, 0, 0, 0);
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL stall_resume: got %b want 1", if_ready); end
    tick();
    n_cmp++;
    if ({ex_valid, ex_rd, ex_imm} !== {1'b1, 5'd7, 32'd3}) begin
      n_bad++; $display("FAIL stall_next: got v=%b rd=%0d imm=%h want v=1 rd=7 imm=3", ex_valid, ex_rd, ex_imm);
    end
  endtask

  task automatic test_flush();
    drive(1, K_ADDI, 8, 0, 0, 9, 0, 0, 0, 1);
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL flush_if_ready: got %b want 0", if_ready); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ex_valid: got %b want 0", ex_valid); end
    drive(1, K_ADD, 9, 6, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL flush_keeps_busy: got %b want 0", if_ready); end
    tick();
    drive(1, K_ADD, 9, 7, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL flush_no_set: got %b want 1", if_ready); end
    tick();
    n_cmp++; if (ex_rd !== 5'd9) begin n_bad++; $display("FAIL flush_next_rd: got %0d want 9", ex_rd); end
    drive(0, K_ADDI, 0, 0, 0, 0, 1, 1, 6, 0);
    tick();
    drive(0, K_ADDI, 0, 0, 0, 0, 1, 1, 9, 0);
    tick();
  endtask

  task automatic test_set_wins();
    drive(1, K_ADDI, 5, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drive(0, K_ADDI, 0, 0, 0, 0, 1, 1, 5, 0);
    tick();
    drive(1, K_ADD, 10, 5, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL set_wins: got %b want 0", if_ready); end
    tick();
    drive(1, K_ADDI, 0, 0, 0, 5, 1, 1, 5, 0);
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL x0_accept: got %b want 1", if_ready); end
    tick();
    n_cmp++;
    if ({ex_valid, ex_we, ex_rd} !== {1'b1, 1'b0, 5'd0}) begin
      n_bad++; $display("FAIL x0_we: got v=%b we=%b rd=%0d want v=1 we=0 rd=0", ex_valid, ex_we, ex_rd);
    end
    drive(1, K_ADD, 11, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL x0_no_stall: got %b want 1", if_ready); end
    tick();
  endtask

  task automatic test_imm_illegal();
    drive(1, K_BEQ, 0, 1, 2, 32'hFFFF_FFFC, 1, 0, 0, 0);
    tick();
    n_cmp++;
    if ({ex_valid, ex_imm, ex_we, ex_illegal} !== {1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL beq_imm: got v=%b imm=%h we=%b ill=%b want v=1 imm=fffffffc we=0 ill=0",
                        ex_valid, ex_imm, ex_we, ex_illegal);
    end
    drive(1, K_ILL, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    n_cmp++;
    if ({ex_valid, ex_opcode, ex_we, ex_illegal} !== {1'b1, 7'h7F, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL illegal: got v=%b op=%h we=%b ill=%b want v=1 op=7f we=0 ill=1",
                        ex_valid, ex_opcode, ex_we, ex_illegal);
    end
  endtask

  task automatic test_random();
    kind_e       k;
    logic [4:0]  q[$];
    logic [4:0]  wa;
    bit          wen, er;
    logic [151:0] got, want;
    for (int c = 0; c < 3000; c++) begin
      k = kind_e'($urandom_range(0, NKIND - 1));
      q.delete();
      for (int r = 1; r < NREG; r++) if (mbusy[r]) q.push_back(5'(r));
      wen = 1'b0; wa = 5'd0;
      if (q.size() > 0 && $urandom_range(0, 99) < 35) begin
        wen = 1'b1; wa = q[$urandom_range(0, q.size() - 1)];
      end
      drive($urandom_range(0, 99) < 80, k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), rand_imm(k), $urandom_range(0, 99) < 70, wen, wa,
            $urandom_range(0, 99) < 5);
      er = exp_ready();
      n_cmp++;
      if (if_ready !== er) begin n_bad++; $display("FAIL rnd_if_ready c%0d: got %b want %b", c, if_ready, er); end
      n_cmp++;
      if ({rf_raddr1, rf_raddr2} !== {if_instr[19:15], if_instr[24:20]}) begin
        n_bad++; $display("FAIL rnd_raddr c%0d: got %0d/%0d want %0d/%0d", c, rf_raddr1, rf_raddr2,
                          if_instr[19:15], if_instr[24:20]);
      end
      tick();
      n_cmp++;
      if (ex_valid !== mex.valid) begin n_bad++; $display("FAIL rnd_ex_valid c%0d: got %b want %b", c, ex_valid, mex.valid); end
      got  = {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7, ex_we, ex_illegal};
      want = {mex.pc, mex.rs1v, mex.rs2v, mex.imm, mex.rd, mex.op, mex.f3, mex.f7, mex.we, mex.ill};
      n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL rnd_ex_fields c%0d: got %h want %h", c, got, want); end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, K_ADDI, 3, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drive(0, K_ADDI, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, K_ADD, 4, 3, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL rst_pre_stall: got %b want 0", if_ready); end
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({if_ready, ex_valid} !== 2'b10) begin
      n_bad++; $display("FAIL rst_mid_stall: got rdy=%b v=%b want rdy=1 v=0", if_ready, ex_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw();
    test_stall();
    test_flush();
    test_set_wins();
    test_imm_illegal();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
